cwe1280_req_queue: RTL and testbench

//   Upstream request front-end for the ID-gated protected register (cwe1280_fixed).
//   - Captures each {usr_id, data} write request atomically at handshake and buffers it in a FIFO.
//   - Checks the captured ID, never a live input. Forwards only authorized requests downstream.
//   - Drops, counts and flags unauthorized requests; locks the request port out after repeated abuse.

---
 rtl/cwe1280_pkg.sv | 19 +
 rtl/cwe1280_sync_fifo.sv | 58 +++++
 rtl/cwe1280_req_queue.sv | 146 ++++++++++++++
 tb/tb_cwe1280_req_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cwe1280_pkg.sv
// rtl/cwe1280_pkg.sv - shared types and defaults for the protected-register request front-end
package cwe1280_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ID_W_DEFAULT   = 3;
    localparam logic [ID_W_DEFAULT-1:0] AUTH_ID_DEFAULT = 3'h4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W_DEFAULT-1:0]   usr_id;
        logic [DATA_W_DEFAULT-1:0] data;
    } req_t;

endpackage

// File: rtl/cwe1280_sync_fifo.sv
// rtl/cwe1280_sync_fifo.sv - single-clock FIFO with occupancy count, power-of-two depth
module cwe1280_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cwe1280_req_queue.sv
// rtl/cwe1280_req_queue.sv - ID-checked request queue with violation counting and lockout
module cwe1280_req_queue
    import cwe1280_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEFAULT,
    parameter int                ID_W        = ID_W_DEFAULT,
    parameter logic [ID_W-1:0]   AUTH_ID     = ID_W'(AUTH_ID_DEFAULT),
    parameter int                DEPTH       = 4,
    parameter int                VIOL_W      = 8,
    parameter int                LOCK_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_usr_id,
    input  logic [DATA_W-1:0] req_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_usr_id,
    output logic [DATA_W-1:0] out_data,
    output logic              viol_pulse,
    output logic [VIOL_W-1:0] viol_count,
    output logic              lockout,
    input  logic              clr_lockout
);

    localparam int EW = ID_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(LOCK_THRESH + 1);
    localparam logic [TW-1:0] THRESH = TW'(LOCK_THRESH);

    state_t            state;
    state_t            state_next;
    logic              pop;
    logic              pop_auth;
    logic [EW-1:0]     fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_fifo_full;
    logic [ID_W-1:0]   hold_id;
    logic [DATA_W-1:0] hold_data;
    logic [TW-1:0]     consec;
    logic [TW-1:0]     consec_inc;

    // Id and data travel together through the FIFO, so the check below only
    // ever sees the values captured at the handshake.
    cwe1280_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_valid && req_ready),
        .wr_data ({req_usr_id, req_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign unused_fifo_full = fifo_full;
    assign req_ready        = (fifo_count != CW'(DEPTH)) && !lockout;
    assign pop_auth         = (fifo_rd[EW-1:DATA_W] == AUTH_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) begin
            state_next = pop_auth ? ISSUE : DROP;
        end
    end

    // Held values are only exposed while issuing, so a dropped entry's id or
    // data never leaks onto the downstream bus.
    assign out_valid  = (state == ISSUE);
    assign out_usr_id = out_valid ? hold_id   : '0;
    assign out_data   = out_valid ? hold_data : '0;
    assign viol_pulse = (state == DROP);
    assign consec_inc = (consec == THRESH) ? consec : consec + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_id    <= '0;
            hold_data  <= '0;
            viol_count <= '0;
            consec     <= '0;
            lockout    <= 1'b0;
        end else begin
            if (pop) begin
                {hold_id, hold_data} <= fifo_rd;
            end
            if (viol_pulse && (viol_count != '1)) begin
                viol_count <= viol_count + 1'b1;
            end
            if (clr_lockout) begin
                consec  <= '0;
                lockout <= 1'b0;
            end else begin
                if (viol_pulse) begin
                    consec <= consec_inc;
                    if (consec_inc == THRESH) begin
                        lockout <= 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    consec <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cwe1280_req_queue.sv
// tb/tb_cwe1280_req_queue.sv - scoreboard bench for the ID-gated request queue
module tb_cwe1280_req_queue;
    import cwe1280_pkg::*;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_usr_id;
    logic [7:0] req_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_usr_id;
    logic [7:0] out_data;
    logic       viol_pulse;
    logic [7:0] viol_count;
    logic       lockout;
    logic       clr_lockout;

    req_t exp_q[$];
    int   exp_drops;
    int   n_cmp;
    int   n_bad;
    int   n_fwd;

    cwe1280_req_queue dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_usr_id  (req_usr_id),
        .req_data    (req_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_usr_id  (out_usr_id),
        .out_data    (out_data),
        .viol_pulse  (viol_pulse),
        .viol_count  (viol_count),
        .lockout     (lockout),
        .clr_lockout (clr_lockout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every downstream accept and every drop pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_fwd++;
                if (exp_q.size() == 0) begin
                    check("unexpected_forward", {21'd0, out_usr_id, out_data}, 32'hFFFF_FFFF);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("out_usr_id", 32'(out_usr_id), 32'(e.usr_id));
                    check("out_data", 32'(out_data), 32'(e.data));
                end
            end
            if (viol_pulse) begin
                check("drop_expected", 32'(exp_drops > 0), 32'd1);
                if (exp_drops > 0) exp_drops--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        clr_lockout = 1'b0;
        tick();
        tick();
        exp_q.delete();
        exp_drops = 0;
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] id, input logic [7:0] d);
        int k;
        k = 0;
        req_valid = 1'b1;
        req_usr_id = id;
        req_data = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            k++;
            if (k > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: req_ready stuck low, expected 1");
                req_valid = 1'b0;
                return;
            end
        end
        if (id == 3'h4) exp_q.push_back('{usr_id: id, data: d});
        else exp_drops++;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (10) tick();
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_drops_left"}, 32'(exp_drops), 32'd0);
    endtask

    initial begin
        int sent;
        int fwd0;
        n_cmp = 0; n_bad = 0; n_fwd = 0; exp_drops = 0;
        req_usr_id = '0; req_data = '0; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_id", 32'(out_usr_id), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_viol_pulse", 32'(viol_pulse), 32'd0);
        check("rst_viol_count", 32'(viol_count), 32'd0);
        check("rst_lockout", 32'(lockout), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // 1: authorized request, out_valid exactly two cycles after the handshake
        tick();
        send(3'h4, 8'hAB);
        @(negedge clk);
        check("t1_n1_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_n2_out_valid", 32'(out_valid), 32'd1);
        check("t1_n2_id", 32'(out_usr_id), 32'h4);
        check("t1_n2_data", 32'(out_data), 32'hAB);
        drain_check("t1");
        check("t1_viol_count", 32'(viol_count), 32'd0);

        // 2: unauthorized request is dropped and counted
        send(3'h3, 8'hCD);
        @(negedge clk);
        check("t2_n1_viol", 32'(viol_pulse), 32'd0);
        tick();
        @(negedge clk);
        check("t2_n2_viol", 32'(viol_pulse), 32'd1);
        check("t2_n2_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t2_viol_count", 32'(viol_count), 32'd1);
        drain_check("t2");

        // 3: back-to-back mixed, id changes the cycle after the first handshake
        do_reset();
        send(3'h4, 8'hAB);
        send(3'h3, 8'hCD);
        send(3'h4, 8'hEF);
        drain_check("t3");
        check("t3_viol_count", 32'(viol_count), 32'd1);

        // 4: stalled downstream, 5 accepted (4 FIFO + hold), then all forwarded in order
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        req_valid = 1'b1;
        req_usr_id = 3'h4;
        req_data = 8'h10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                exp_q.push_back('{usr_id: 3'h4, data: req_data});
                sent++;
            end
            tick();
            req_data = 8'h10 + 8'(sent);
        end
        @(negedge clk);
        check("t4_accepted", 32'(sent), 32'd5);
        check("t4_req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        fwd0 = n_fwd;
        out_ready = 1'b1;
        drain_check("t4");
        check("t4_forwarded", 32'(n_fwd - fwd0), 32'd5);

        // 5: three consecutive violations lock the port; clear releases it
        do_reset();
        send(3'h3, 8'h01);
        send(3'h3, 8'h02);
        send(3'h3, 8'h03);
        drain_check("t5");
        @(negedge clk);
        check("t5_lockout", 32'(lockout), 32'd1);
        check("t5_req_ready_locked", 32'(req_ready), 32'd0);
        clr_lockout = 1'b1;
        tick();
        clr_lockout = 1'b0;
        @(negedge clk);
        check("t5_lockout_clr", 32'(lockout), 32'd0);
        check("t5_req_ready_clr", 32'(req_ready), 32'd1);
        check("t5_viol_count", 32'(viol_count), 32'd3);

        // 6: reset while issuing with entries queued discards everything
        do_reset();
        out_ready = 1'b0;
        send(3'h4, 8'h31);
        send(3'h4, 8'h32);
        send(3'h4, 8'h33);
        tick();
        @(negedge clk);
        check("t6_pre_out_valid", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        exp_drops = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_viol_count", 32'(viol_count), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd1);
        out_ready = 1'b1;
        fwd0 = n_fwd;
        drain_check("t6");
        check("t6_no_stale", 32'(n_fwd - fwd0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
